pipeline_dmem_initiator: RTL and testbench

Multi-cycle data-memory initiator for the pipelined core; the producing end of the pipeline control's `want_stall` / `no_stall` handshake. Accepts the memory-stage read/write enables, runs a request/acknowledge transaction on the data bus, and holds `want_stall` high until the transaction completes. Read data is then held stable until the pipeline advances.

---
 rtl/pipeline_dmem_initiator_pkg.sv | 22 ++
 rtl/pipeline_dmem_initiator_timeout.sv | 39 +++
 rtl/pipeline_dmem_initiator.sv | 137 +++++++++++++
 tb/tb_pipeline_dmem_initiator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_dmem_initiator_pkg.sv
// Shared constants and types for the pipelined-core data-memory initiator.
// Optional feature macro: DMEM_TIMEOUT_EN (bus-acknowledge timeout and sticky bus_error).
package pipeline_dmem_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;
  localparam int          DMEM_CNT_W           = 16;

  // Everything the initiator presents on the bus for one transaction.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_cmd_t;

endpackage

// File: rtl/pipeline_dmem_initiator_timeout.sv
// Ack-wait counter for the data-memory initiator; used only when DMEM_TIMEOUT_EN is defined.
// Counts REQ cycles without ack and flags the final allowed cycle.
module dmem_timeout_counter
  import pipeline_dmem_initiator_pkg::*;
#(
  parameter int unsigned LIMIT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [DMEM_CNT_W-1:0] LAST = DMEM_CNT_W'(LIMIT - 1);

  logic [DMEM_CNT_W-1:0] count_q, count_d;

  // Saturates at LAST so an unserviced wait cannot wrap back to a small count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  assign expired = (count_q == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_dmem_initiator.sv
// Multi-cycle data-memory initiator: drives want_stall to pipeline control while a bus
// request/ack transaction runs. Optional feature macro: DMEM_TIMEOUT_EN.
module pipeline_dmem_initiator
  import pipeline_dmem_initiator_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        data_mem_read_enable,
  input  logic        data_mem_write_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  input  logic [3:0]  mem_write_mask,
  input  logic        no_stall,
  output logic        want_stall,
  output logic [31:0] read_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
`ifdef DMEM_TIMEOUT_EN
  output logic        bus_error,
`endif
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

`ifdef DMEM_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT;
`endif

  dmem_state_t state_q, state_d;
  bus_cmd_t    cmd_q, cmd_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] read_data_q, read_data_d;
  logic        error_q, error_d;
  logic        op;
  logic        timed_out;

`ifdef DMEM_TIMEOUT_EN
  dmem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q != REQ),
    .enable  ((state_q == REQ) && !bus_ack),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  assign op = data_mem_read_enable | data_mem_write_enable;

  // NOTE: every signal gets its default before the case; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    bus_req_d   = bus_req_q;
    read_data_d = read_data_q;
    error_d     = error_q;
    want_stall  = 1'b0;

    unique case (state_q)
      IDLE: begin
        want_stall = op;
        if (op) begin
          cmd_d     = '{we:    data_mem_write_enable,
                        addr:  mem_address,
                        wdata: mem_write_data,
                        wmask: mem_write_mask};
          bus_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        want_stall = 1'b1;
        // A real ack beats a timeout landing in the same cycle.
        if (bus_ack) begin
          if (!cmd_q.we) begin
            read_data_d = bus_rdata;
          end
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else if (timed_out) begin
          read_data_d = '0;
          error_d     = 1'b1;
          bus_req_d   = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Another stall source may still hold the pipeline; wait for it to advance.
        if (no_stall) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      bus_req_q   <= 1'b0;
      read_data_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      bus_req_q   <= bus_req_d;
      read_data_q <= read_data_d;
      error_q     <= error_d;
    end
  end

  assign read_data = read_data_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = cmd_q.we;
  assign bus_addr  = cmd_q.addr;
  assign bus_wdata = cmd_q.wdata;
  assign bus_wmask = cmd_q.wmask;
`ifdef DMEM_TIMEOUT_EN
  assign bus_error = error_q;
`else
  // Without the timeout the error path is never taken; keep the register trivially consumed.
  logic unused_error;
  assign unused_error = error_q;
`endif

endmodule

// File: tb/tb_pipeline_dmem_initiator.sv
// Self-checking bench for pipeline_dmem_initiator: table of transactions plus reset and
// timeout corner cases (timeout cases only when DMEM_TIMEOUT_EN is defined).
module tb_pipeline_dmem_initiator;
  import pipeline_dmem_initiator_pkg::*;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        data_mem_read_enable, data_mem_write_enable;
  logic [31:0] mem_address, mem_write_data;
  logic [3:0]  mem_write_mask;
  logic        no_stall;
  logic        want_stall;
  logic [31:0] read_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ack;
  logic [31:0] bus_rdata;
`ifdef DMEM_TIMEOUT_EN
  logic        bus_error;
`endif

  always #5 clock = ~clock;

`ifdef DMEM_TIMEOUT_EN
  pipeline_dmem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
`else
  pipeline_dmem_initiator dut (
`endif
    .clock                 (clock),
    .reset                 (reset),
    .data_mem_read_enable  (data_mem_read_enable),
    .data_mem_write_enable (data_mem_write_enable),
    .mem_address           (mem_address),
    .mem_write_data        (mem_write_data),
    .mem_write_mask        (mem_write_mask),
    .no_stall              (no_stall),
    .want_stall            (want_stall),
    .read_data             (read_data),
    .bus_req               (bus_req),
    .bus_we                (bus_we),
    .bus_addr              (bus_addr),
    .bus_wdata             (bus_wdata),
    .bus_wmask             (bus_wmask),
`ifdef DMEM_TIMEOUT_EN
    .bus_error             (bus_error),
`endif
    .bus_ack               (bus_ack),
    .bus_rdata             (bus_rdata)
  );

  typedef struct {
    bit          is_write;
    bit          also_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          ack_cycle;   // 0 = never acknowledged
    logic [31:0] rdata;
    int          done_hold;
    bit          spurious;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    int          stall;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] model_rd;
  vec_t        vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset                 = 1'b1;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    mem_address           = '0;
    mem_write_data        = '0;
    mem_write_mask        = '0;
    no_stall              = 1'b0;
    bus_ack               = 1'b0;
    bus_rdata             = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_rd = '0;
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    exp_t got;
    int   stall;
    bit   done;
    bit   changed;
    e.rd    = (v.ack_cycle == 0) ? 32'h0 : (v.is_write ? model_rd : v.rdata);
    e.stall = (v.ack_cycle == 0) ? TO + 1 : v.ack_cycle + 1;
    model_rd = e.rd;
    sb.push_back(e);

    @(posedge clock); #1;
    data_mem_write_enable = v.is_write;
    data_mem_read_enable  = !v.is_write || v.also_read;
    mem_address           = v.addr;
    mem_write_data        = v.wdata;
    mem_write_mask        = v.mask;
    no_stall              = 1'b0;
    bus_rdata             = v.rdata;
    stall   = 0;
    done    = 1'b0;
    changed = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clock); #1;
      end
      bus_ack = (cyc != 0) && (cyc == v.ack_cycle);
      @(negedge clock);
      if (cyc == 0) check("stall_cycle0", want_stall, 1);
      if (cyc == 1) begin
        check("bus_req_cycle1", bus_req, 1);
        check("bus_we", bus_we, v.is_write);
        check("bus_addr", bus_addr, v.addr);
        check("bus_wdata", bus_wdata, v.wdata);
        check("bus_wmask", bus_wmask, v.mask);
      end
      if (cyc >= 1 && want_stall &&
          (bus_req !== 1'b1 || bus_we !== v.is_write || bus_addr !== v.addr ||
           bus_wdata !== v.wdata || bus_wmask !== v.mask))
        changed = 1'b1;
      if (want_stall) stall++;
      else done = 1'b1;
    end
    bus_ack = 1'b0;
    check("done_within_budget", done, 1);
    check("bus_outputs_constant", changed, 0);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      got = sb.pop_front();
      check("stall_cycles", stall, got.stall);
      check("read_data", read_data, got.rd);
    end
    check("bus_req_dropped", bus_req, 0);
    check("state_done", dut.state_q, DONE);

    for (int h = 0; h < v.done_hold; h++) begin
      @(posedge clock); #1;
      bus_ack   = v.spurious && (h == 1);
      bus_rdata = 32'hBAD0_0000 ^ h;
      @(negedge clock);
      check("hold_want_stall", want_stall, 0);
      check("hold_read_data", read_data, e.rd);
      check("hold_state_done", dut.state_q, DONE);
    end
    bus_ack  = 1'b0;
    no_stall = 1'b1;
    @(posedge clock); #1;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    no_stall              = 1'b0;
    @(negedge clock);
    check("idle_after_advance", dut.state_q, IDLE);
    check("idle_read_data", read_data, e.rd);
  endtask

  initial begin
    vecs[0] = '{0, 0, 32'h0000_0100, 32'h0,         4'h0,    1, 32'hDEAD_BEEF, 0, 0};
    vecs[1] = '{1, 0, 32'h0000_0204, 32'h1234_5678, 4'b0011, 5, 32'hFFFF_FFFF, 0, 0};
    vecs[2] = '{0, 0, 32'h0000_1000, 32'h0,         4'h0,    3, 32'hA5A5_5A5A, 3, 1};
    vecs[3] = '{1, 1, 32'h0000_0208, 32'h0BAD_F00D, 4'hF,    2, 32'h1111_1111, 1, 0};
    vecs[4] = '{0, 0, 32'hFFFF_FFFC, 32'h0,         4'h0,    1, 32'h0000_0000, 0, 0};

    do_reset();
    @(negedge clock);
    check("rst_state", dut.state_q, IDLE);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_wmask", bus_wmask, 0);
    check("rst_read_data", read_data, 0);
    check("rst_want_stall", want_stall, 0);
`ifdef DMEM_TIMEOUT_EN
    check("rst_bus_error", bus_error, 0);
`endif

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Reset in the second REQ cycle abandons the request.
    @(posedge clock); #1;
    data_mem_read_enable = 1'b1;
    mem_address          = 32'h0000_0300;
    bus_ack              = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset                = 1'b1;
    data_mem_read_enable = 1'b0;
    @(negedge clock);
    check("req2_bus_req", bus_req, 1);
    @(posedge clock); #1;
    reset    = 1'b0;
    model_rd = '0;
    @(negedge clock);
    check("rst_in_req_state", dut.state_q, IDLE);
    check("rst_in_req_bus_req", bus_req, 0);
    check("rst_in_req_read_data", read_data, 0);

`ifdef DMEM_TIMEOUT_EN
    run_txn('{0, 0, 32'h0000_0400, 32'h0, 4'h0, TO, 32'hCAFE_F00D, 0, 0});
    check("coincident_no_error", bus_error, 0);
    run_txn('{0, 0, 32'h0000_0404, 32'h0, 4'h0, 0, 32'h7777_7777, 0, 0});
    check("timeout_bus_error", bus_error, 1);
    run_txn('{0, 0, 32'h0000_0408, 32'h0, 4'h0, 2, 32'h2468_ACE0, 0, 0});
    check("bus_error_sticky", bus_error, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
